// File: rtl/maxnet_pkg.sv
// Shared types and arithmetic helpers for the MaxNet winner-take-all engine.
package maxnet_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Why the run ended; published as the stalled/timeout flags in DONE.
   typedef enum logic [1:0] {
      END_SETTLED = 2'd0,
      END_STALL   = 2'd1,
      END_TIMEOUT = 2'd2
   } end_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic signed [63:0] relu(input logic signed [63:0] v);
      return (v < 64'sd0) ? 64'sd0 : v;
   endfunction

endpackage

// File: rtl/maxnet_param_if.sv
// Start/done handshake and activation bus between the score producer and the MaxNet engine.
interface maxnet_param_if #(
   parameter int N        = 4,
   parameter int W        = 5,
   parameter int MAX_ITER = 15
);
   localparam int IW = maxnet_pkg::clog2(N);
   localparam int CW = maxnet_pkg::clog2(MAX_ITER + 1);

   logic                 start;
   logic signed [W-1:0]  epsilon;
   logic [N*W-1:0]       x_flat;
   logic                 busy;
   logic                 done;
   logic [N*W-1:0]       pu_out;
   logic [IW-1:0]        winner;
   logic                 winner_valid;
   logic                 stalled;
   logic                 timeout;
   logic [CW-1:0]        iter_count;

   modport master (
      output start, epsilon, x_flat,
      input  busy, done, pu_out, winner, winner_valid, stalled, timeout, iter_count
   );

   modport slave (
      input  start, epsilon, x_flat,
      output busy, done, pu_out, winner, winner_valid, stalled, timeout, iter_count
   );
endinterface

// File: rtl/maxnet_pe.sv
// One MaxNet processing element: x' = relu(sat_W(x + floor(eps * (S - x) / 2^FRAC))).
module maxnet_pe
   import maxnet_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 5,
   parameter int FRAC = 3
) (
   input  logic signed [W-1:0]          x_i,
   input  logic signed [W+clog2(N)-1:0] s_i,
   input  logic signed [W-1:0]          eps_i,
   output logic signed [W-1:0]          x_o
);
   localparam int SW = W + clog2(N);
   localparam int PW = W + SW + 1;

   logic signed [PW-1:0] diff;
   logic signed [PW-1:0] eps_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;
   logic signed [PW:0]   acc;

   always_comb begin
      diff    = PW'(s_i) - PW'(x_i);
      eps_ext = PW'(eps_i);
      prod    = diff * eps_ext;
      // Arithmetic shift rounds toward minus infinity, so small inhibitions still bite.
      shifted = prod >>> FRAC;
      acc     = (PW+1)'(x_i) + (PW+1)'(shifted);
      x_o     = W'(relu(sat_w(64'(acc), W)));
   end

endmodule

// File: rtl/maxnet_param.sv
// Iterative MaxNet engine: FSM, activation registers, sum tree, convergence detection
// and winner encoding around N combinational PEs.
module maxnet_param
   import maxnet_pkg::*;
#(
   parameter int N        = 4,
   parameter int W        = 5,
   parameter int FRAC     = 3,
   parameter int MAX_ITER = 15
) (
   input  logic          clk,
   input  logic          rst,
   maxnet_param_if.slave bus
);
   localparam int SW = W + clog2(N);
   localparam int IW = clog2(N);
   localparam int CW = clog2(MAX_ITER + 1);
   localparam int NW = clog2(N + 1);

   state_e              state_q;
   end_e                end_q;
   logic signed [W-1:0] x_q [N];
   logic signed [W-1:0] x_d [N];
   logic                busy_q;
   logic                done_q;
   logic                wv_q;
   logic                stalled_q;
   logic                timeout_q;
   logic [IW-1:0]       winner_q;
   logic [CW-1:0]       iter_q;

   logic signed [SW-1:0] s_sum;
   logic [NW-1:0]        nz_cnt;
   logic [IW-1:0]        win_idx;
   logic                 changed;
   logic [N*W-1:0]       pu_flat;

   // NOTE: every always_comb output gets a default before the loop, so no latch is inferred;
   // blocking '=' is right here because the loop accumulates within one evaluation.
   always_comb begin
      s_sum   = '0;
      nz_cnt  = '0;
      win_idx = '0;
      pu_flat = '0;
      for (int i = 0; i < N; i++) begin
         s_sum = s_sum + SW'(x_q[i]);
         if (x_q[i] != '0) begin
            nz_cnt  = nz_cnt + NW'(1);
            win_idx = IW'(i);
         end
         pu_flat[i*W +: W] = x_q[i];
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_pe
      maxnet_pe #(
         .N    (N),
         .W    (W),
         .FRAC (FRAC)
      ) u_pe (
         .x_i   (x_q[g]),
         .s_i   (s_sum),
         .eps_i (bus.epsilon),
         .x_o   (x_d[g])
      );
   end

   // Kept apart from the sum tree so the PE feedback path does not look like a loop.
   always_comb begin
      changed = 1'b0;
      for (int i = 0; i < N; i++) begin
         changed = changed | (x_d[i] != x_q[i]);
      end
   end

   // NOTE: sequential state uses '<=' only. The activation array is a handful of
   // flops that feed outputs, so it is reset like any other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         end_q     <= END_SETTLED;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wv_q      <= 1'b0;
         stalled_q <= 1'b0;
         timeout_q <= 1'b0;
         winner_q  <= '0;
         iter_q    <= '0;
         for (int i = 0; i < N; i++) x_q[i] <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  for (int i = 0; i < N; i++) begin
                     x_q[i] <= W'(relu(64'($signed(bus.x_flat[i*W +: W]))));
                  end
                  iter_q    <= '0;
                  busy_q    <= 1'b1;
                  wv_q      <= 1'b0;
                  winner_q  <= '0;
                  stalled_q <= 1'b0;
                  timeout_q <= 1'b0;
                  end_q     <= END_SETTLED;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               if (nz_cnt < NW'(2)) begin
                  end_q   <= END_SETTLED;
                  state_q <= S_DONE;
               end else if (!changed) begin
                  end_q   <= END_STALL;
                  state_q <= S_DONE;
               end else if (iter_q == CW'(MAX_ITER)) begin
                  end_q   <= END_TIMEOUT;
                  state_q <= S_DONE;
               end else begin
                  for (int i = 0; i < N; i++) x_q[i] <= x_d[i];
                  iter_q <= iter_q + CW'(1);
               end
            end
            S_DONE: begin
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               wv_q      <= (nz_cnt == NW'(1));
               winner_q  <= (nz_cnt == NW'(1)) ? win_idx : '0;
               stalled_q <= (end_q == END_STALL);
               timeout_q <= (end_q == END_TIMEOUT);
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.pu_out       = pu_flat;
   assign bus.winner       = winner_q;
   assign bus.winner_valid = wv_q;
   assign bus.stalled      = stalled_q;
   assign bus.timeout      = timeout_q;
   assign bus.iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_param.sv
// Directed bench for maxnet_param: vector table on the default build, plus timeout,
// handshake/reset sequences and an 8-channel run against an integer reference model.
module tb_maxnet_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   maxnet_param_if #(.N(4), .W(5), .MAX_ITER(15)) if_base ();
   maxnet_param_if #(.N(4), .W(5), .MAX_ITER(1))  if_to ();
   maxnet_param_if #(.N(8), .W(8), .MAX_ITER(15)) if_wide ();

   maxnet_param #(.N(4), .W(5), .FRAC(3), .MAX_ITER(15)) u_base (.clk(clk), .rst(rst), .bus(if_base));
   maxnet_param #(.N(4), .W(5), .FRAC(3), .MAX_ITER(1))  u_to   (.clk(clk), .rst(rst), .bus(if_to));
   maxnet_param #(.N(8), .W(8), .FRAC(4), .MAX_ITER(15)) u_wide (.clk(clk), .rst(rst), .bus(if_wide));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
      return {d[4:0], c[4:0], b[4:0], a[4:0]};
   endfunction

   typedef struct {
      string       name;
      logic [4:0]  eps;
      logic [19:0] x;
      logic [19:0] pu;
      int          win;
      bit          wv;
      bit          st;
      bit          to;
      int          iters;
   } vec_t;

   function automatic vec_t mk(input string n, input logic [4:0] e, input logic [19:0] x,
                               input logic [19:0] pu, input int win, input bit wv,
                               input bit st, input bit to, input int it);
      vec_t r;
      r.name = n; r.eps = e; r.x = x; r.pu = pu; r.win = win;
      r.wv = wv; r.st = st; r.to = to; r.iters = it;
      return r;
   endfunction

   // Start one run on the default build and count negedges until done is seen.
   task automatic run_base(input logic [4:0] eps, input logic [19:0] x, output int lat);
      @(negedge clk);
      if_base.epsilon = eps;
      if_base.x_flat  = x;
      if_base.start   = 1'b1;
      @(negedge clk);
      if_base.start = 1'b0;
      lat = 0;
      while (if_base.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   vec_t tbl [8];
   int   m  [8];
   int   mn [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt;
      int iters;
      int nz;
      int s;
      int t;
      bit chg;
      logic [63:0] exp_pu;

      if_base.start = 1'b0; if_base.epsilon = '0; if_base.x_flat = '0;
      if_to.start   = 1'b0; if_to.epsilon   = '0; if_to.x_flat   = '0;
      if_wide.start = 1'b0; if_wide.epsilon = '0; if_wide.x_flat = '0;

      tbl[0] = mk("base",   5'h1E, pack4(8, 6, 4, 2),  pack4(4, 0, 0, 0),     0, 1, 0, 0, 2);
      tbl[1] = mk("stall",  5'h00, pack4(8, 6, 4, 2),  pack4(8, 6, 4, 2),     0, 0, 1, 0, 0);
      tbl[2] = mk("zeros",  5'h1E, pack4(0, 0, 0, 0),  pack4(0, 0, 0, 0),     0, 0, 0, 0, 0);
      tbl[3] = mk("single", 5'h1E, pack4(0, 0, 7, 0),  pack4(0, 0, 7, 0),     2, 1, 0, 0, 0);
      tbl[4] = mk("negin",  5'h1E, pack4(0, 24, 0, 5), pack4(0, 0, 0, 5),     3, 1, 0, 0, 0);
      tbl[5] = mk("half",   5'h1C, pack4(3, 5, 0, 0),  pack4(0, 3, 0, 0),     1, 1, 0, 0, 1);
      tbl[6] = mk("tie",    5'h1E, pack4(4, 4, 0, 0),  pack4(0, 0, 0, 0),     0, 0, 0, 0, 4);
      tbl[7] = mk("sat",    5'h08, pack4(4, 4, 4, 4),  pack4(15, 15, 15, 15), 0, 0, 1, 0, 1);

      #2 rst = 1'b0;
      #1;
      check("reset busy", if_base.busy, 0);
      check("reset done", if_base.done, 0);
      check("reset pu", if_base.pu_out, 0);
      check("reset flags", {if_base.winner, if_base.winner_valid, if_base.stalled,
                            if_base.timeout, if_base.iter_count}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 8; v++) begin
         run_base(tbl[v].eps, tbl[v].x, lat);
         check($sformatf("%s latency", tbl[v].name), lat, tbl[v].iters + 2);
         check($sformatf("%s pu", tbl[v].name), if_base.pu_out, tbl[v].pu);
         check($sformatf("%s winner", tbl[v].name), if_base.winner, tbl[v].win);
         check($sformatf("%s winner_valid", tbl[v].name), if_base.winner_valid, tbl[v].wv);
         check($sformatf("%s stalled", tbl[v].name), if_base.stalled, tbl[v].st);
         check($sformatf("%s timeout", tbl[v].name), if_base.timeout, tbl[v].to);
         check($sformatf("%s iter", tbl[v].name), if_base.iter_count, tbl[v].iters);
         check($sformatf("%s busy", tbl[v].name), if_base.busy, 0);
         @(negedge clk);
         check($sformatf("%s done pulse", tbl[v].name), if_base.done, 0);
      end

      // Baseline cycle by cycle, with a stray start while busy.
      @(negedge clk);
      if_base.epsilon = 5'h1E;
      if_base.x_flat  = pack4(8, 6, 4, 2);
      if_base.start   = 1'b1;
      @(negedge clk);
      check("seq busy k", if_base.busy, 1);
      check("seq load", if_base.pu_out, pack4(8, 6, 4, 2));
      check("seq flags clear", {if_base.winner_valid, if_base.iter_count}, 0);
      if_base.x_flat = pack4(0, 0, 0, 0);
      @(negedge clk);
      check("seq iter1 pu", if_base.pu_out, pack4(5, 2, 0, 0));
      check("seq iter1 cnt", if_base.iter_count, 1);
      if_base.start  = 1'b0;
      if_base.x_flat = pack4(8, 6, 4, 2);
      @(negedge clk);
      check("seq iter2 pu", if_base.pu_out, pack4(4, 0, 0, 0));
      check("seq iter2 busy", if_base.busy, 1);
      @(negedge clk);
      check("seq pre-done", {if_base.busy, if_base.done}, 2'b10);
      @(negedge clk);
      check("seq done", {if_base.busy, if_base.done}, 2'b01);
      check("seq result", {if_base.winner, if_base.winner_valid, if_base.stalled,
                           if_base.timeout, if_base.iter_count}, {2'd0, 1'b1, 1'b0, 1'b0, 4'd2});
      repeat (3) @(negedge clk);
      check("seq hold pu", if_base.pu_out, pack4(4, 0, 0, 0));
      check("seq hold result", {if_base.done, if_base.winner_valid, if_base.iter_count},
            {1'b0, 1'b1, 4'd2});

      // Timeout build: one iteration allowed.
      @(negedge clk);
      if_to.epsilon = 5'h1E;
      if_to.x_flat  = pack4(8, 6, 4, 2);
      if_to.start   = 1'b1;
      @(negedge clk);
      if_to.start = 1'b0;
      lat = 0;
      while (if_to.done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("to latency", lat, 3);
      check("to pu", if_to.pu_out, pack4(5, 2, 0, 0));
      check("to timeout", if_to.timeout, 1);
      check("to iter", if_to.iter_count, 1);
      check("to wv/stalled", {if_to.winner_valid, if_to.stalled}, 0);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      if_base.epsilon = 5'h1E;
      if_base.x_flat  = pack4(4, 4, 0, 0);
      if_base.start   = 1'b1;
      @(negedge clk);
      if_base.start = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst busy", if_base.busy, 0);
      check("midrst pu", if_base.pu_out, 0);
      check("midrst iter", if_base.iter_count, 0);
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (if_base.done === 1'b1) cnt++;
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (if_base.done === 1'b1) cnt++;
      end
      check("midrst no done", cnt, 0);

      run_base(5'h1E, pack4(8, 6, 4, 2), lat);
      check("rerun latency", lat, 4);
      check("rerun pu", if_base.pu_out, pack4(4, 0, 0, 0));
      check("rerun result", {if_base.winner, if_base.winner_valid, if_base.iter_count},
            {2'd0, 1'b1, 4'd2});

      // Eight channels, Q4.4, eps = -0.125, tracked against an integer model.
      for (int i = 0; i < 8; i++) m[i] = 0;
      m[0] = 16; m[1] = 15; m[2] = 3;
      @(negedge clk);
      if_wide.epsilon = 8'hFE;
      if_wide.x_flat  = {40'd0, 8'd3, 8'd15, 8'd16};
      if_wide.start   = 1'b1;
      @(negedge clk);
      if_wide.start = 1'b0;
      exp_pu = '0;
      for (int i = 0; i < 8; i++) exp_pu[i*8 +: 8] = 8'(m[i]);
      check("wide load", if_wide.pu_out, exp_pu);
      iters = 0;
      for (int step = 0; step < 20; step++) begin
         s  = 0;
         nz = 0;
         for (int i = 0; i < 8; i++) begin
            s += m[i];
            if (m[i] != 0) nz++;
         end
         chg = 1'b0;
         for (int i = 0; i < 8; i++) begin
            t = -2 * (s - m[i]);
            t = (t >= 0) ? t / 16 : -((-t + 15) / 16);
            t = m[i] + t;
            if (t > 127) t = 127;
            if (t < 0) t = 0;
            mn[i] = t;
            if (t != m[i]) chg = 1'b1;
         end
         if (nz <= 1 || !chg || iters == 15) break;
         for (int i = 0; i < 8; i++) m[i] = mn[i];
         iters++;
         @(negedge clk);
         exp_pu = '0;
         for (int i = 0; i < 8; i++) exp_pu[i*8 +: 8] = 8'(m[i]);
         check($sformatf("wide iter%0d pu", iters), if_wide.pu_out, exp_pu);
         check($sformatf("wide iter%0d cnt", iters), if_wide.iter_count, iters);
      end
      @(negedge clk);
      check("wide pre-done", {if_wide.busy, if_wide.done}, 2'b10);
      @(negedge clk);
      check("wide done", {if_wide.busy, if_wide.done}, 2'b01);
      check("wide winner", if_wide.winner, 0);
      check("wide winner_valid", if_wide.winner_valid, 1);
      check("wide iter", if_wide.iter_count, iters);
      check("wide flags", {if_wide.stalled, if_wide.timeout}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
